// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
// Shares the single DDR RAM wrapper port between three requesters:
// the record stream (writes), the playback stream (reads) and the
// PicoBlaze port-mapped accesses (reads or writes). The arbiter owns the
// wrapper handshake, bounds-checks every address against the RAM's
// reported size and gives up on reads that never return data.
// Record always wins. Playback and PicoBlaze share the remaining bandwidth
// through a round-robin pointer.
module ram_access_arbiter #(
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              pb_reset,

    // record stream, write-only
    input  logic              rec_req,
    input  logic [ADDR_W-1:0] rec_addr,
    input  logic [DATA_W-1:0] rec_data,
    output logic              rec_ack,

    // playback stream, read-only
    input  logic              play_req,
    input  logic [ADDR_W-1:0] play_addr,
    output logic              play_ack,

    // PicoBlaze single accesses
    input  logic              pb_req,
    input  logic              pb_we,
    input  logic [ADDR_W-1:0] pb_addr,
    input  logic [DATA_W-1:0] pb_wdata,
    output logic              pb_ack,

    // shared results
    output logic [DATA_W-1:0] rd_data,
    output logic              req_err,
    output logic              busy,

    // RAM wrapper side
    input  logic              ram_rdy,
    input  logic [ADDR_W-1:0] max_ram_address,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enable,
    output logic              ram_read_request,
    output logic              ram_read_ack,
    input  logic [DATA_W-1:0] ram_data_out,
    input  logic              ram_rd_data_pres
);

    // ------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_REQ,
        READ_WAIT,
        READ_ACK
    } state_t;

    typedef enum logic [1:0] {
        SRC_REC,
        SRC_PLAY,
        SRC_PB
    } src_t;

    // The wait counter runs 0 .. TIMEOUT-1, one count per READ_WAIT cycle.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_reg;
    src_t            src_reg;        // requester owning the current access
    logic            rr_play_reg;    // 1: play wins a play/pb tie
    logic [TW-1:0]   timer_reg;      // cycles spent in READ_WAIT

    // ------------------------------------------------------------------
    // Request selection (evaluated every cycle, used only in IDLE)
    // ------------------------------------------------------------------
    logic              sel_valid;
    src_t              sel_src;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_write;
    logic              sel_oob;

    // Pick the winning requester: record first, then the round-robin choice
    // between playback and PicoBlaze. Playback carries no data, so the data
    // bus keeps whatever was last latched.
    always_comb begin
        sel_valid = 1'b0;
        sel_src   = SRC_REC;
        sel_addr  = ram_address;
        sel_data  = ram_data_in;
        sel_write = 1'b0;
        if (rec_req) begin
            sel_valid = 1'b1;
            sel_src   = SRC_REC;
            sel_addr  = rec_addr;
            sel_data  = rec_data;
            sel_write = 1'b1;
        end else if (play_req && (!pb_req || rr_play_reg)) begin
            sel_valid = 1'b1;
            sel_src   = SRC_PLAY;
            sel_addr  = play_addr;
            sel_write = 1'b0;
        end else if (pb_req) begin
            sel_valid = 1'b1;
            sel_src   = SRC_PB;
            sel_addr  = pb_addr;
            sel_data  = pb_wdata;
            sel_write = pb_we;
        end
    end

    // Out-of-range addresses never reach the wrapper as a strobe.
    assign sel_oob = (sel_addr > max_ram_address);

    // ------------------------------------------------------------------
    // Sequencer with registered strobes, acks and data outputs
    // ------------------------------------------------------------------
    // Main FSM: grants, drives the wrapper handshake and completes accesses.
    // A rejected access spends its single ack cycle in WRITE with no strobe
    // raised, which gives it the same grant-to-IDLE timing as a write.
    always_ff @(posedge clk or posedge pb_reset) begin
        if (pb_reset) begin
            state_reg        <= IDLE;
            src_reg          <= SRC_REC;
            rr_play_reg      <= 1'b1;
            timer_reg        <= '0;
            rec_ack          <= 1'b0;
            play_ack         <= 1'b0;
            pb_ack           <= 1'b0;
            rd_data          <= '0;
            req_err          <= 1'b0;
            busy             <= 1'b0;
            ram_address      <= '0;
            ram_data_in      <= '0;
            ram_write_enable <= 1'b0;
            ram_read_request <= 1'b0;
            ram_read_ack     <= 1'b0;
        end else begin
            // every strobe is a single-cycle pulse unless re-asserted below
            rec_ack          <= 1'b0;
            play_ack         <= 1'b0;
            pb_ack           <= 1'b0;
            req_err          <= 1'b0;
            ram_write_enable <= 1'b0;
            ram_read_request <= 1'b0;
            ram_read_ack     <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (ram_rdy && sel_valid) begin
                        src_reg     <= sel_src;
                        ram_address <= sel_addr;
                        ram_data_in <= sel_data;
                        busy        <= 1'b1;
                        if (sel_src != SRC_REC) begin
                            rr_play_reg <= ~rr_play_reg;
                        end
                        if (sel_oob) begin
                            // rejected: ack with error, no RAM activity
                            rec_ack   <= (sel_src == SRC_REC);
                            play_ack  <= (sel_src == SRC_PLAY);
                            pb_ack    <= (sel_src == SRC_PB);
                            req_err   <= 1'b1;
                            state_reg <= WRITE;
                        end else if (sel_write) begin
                            rec_ack          <= (sel_src == SRC_REC);
                            pb_ack           <= (sel_src == SRC_PB);
                            ram_write_enable <= 1'b1;
                            state_reg        <= WRITE;
                        end else begin
                            ram_read_request <= 1'b1;
                            state_reg        <= READ_REQ;
                        end
                    end
                end

                WRITE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                READ_REQ: begin
                    timer_reg <= '0;
                    state_reg <= READ_WAIT;
                end

                READ_WAIT: begin
                    if (ram_rd_data_pres) begin
                        rd_data      <= ram_data_out;
                        ram_read_ack <= 1'b1;
                        play_ack     <= (src_reg == SRC_PLAY);
                        pb_ack       <= (src_reg == SRC_PB);
                        state_reg    <= READ_ACK;
                    end else if (timer_reg == T_LAST) begin
                        // give up: the wrapper still gets its read_ack so
                        // its own handshake is closed out
                        rd_data      <= '0;
                        ram_read_ack <= 1'b1;
                        play_ack     <= (src_reg == SRC_PLAY);
                        pb_ack       <= (src_reg == SRC_PB);
                        req_err      <= 1'b1;
                        state_reg    <= READ_ACK;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                READ_ACK: begin
                    timer_reg <= '0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed testbench for ram_access_arbiter.
// A small wrapper model stores writes and answers reads after a
// programmable delay (pres_delay < 0 means the data never arrives).
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_ram_access_arbiter;

    localparam int ADDR_W  = 26;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 8;
    localparam logic [ADDR_W-1:0] MAX_ADDR = 26'h3FF;

    logic              clk = 1'b0;
    logic              pb_reset;
    logic              rec_req;
    logic [ADDR_W-1:0] rec_addr;
    logic [DATA_W-1:0] rec_data;
    logic              rec_ack;
    logic              play_req;
    logic [ADDR_W-1:0] play_addr;
    logic              play_ack;
    logic              pb_req;
    logic              pb_we;
    logic [ADDR_W-1:0] pb_addr;
    logic [DATA_W-1:0] pb_wdata;
    logic              pb_ack;
    logic [DATA_W-1:0] rd_data;
    logic              req_err;
    logic              busy;
    logic              ram_rdy;
    logic [ADDR_W-1:0] max_ram_address;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic              ram_write_enable;
    logic              ram_read_request;
    logic              ram_read_ack;
    logic [DATA_W-1:0] ram_data_out = '0;
    logic              ram_rd_data_pres = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_access_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk             (clk),
        .pb_reset        (pb_reset),
        .rec_req         (rec_req),
        .rec_addr        (rec_addr),
        .rec_data        (rec_data),
        .rec_ack         (rec_ack),
        .play_req        (play_req),
        .play_addr       (play_addr),
        .play_ack        (play_ack),
        .pb_req          (pb_req),
        .pb_we           (pb_we),
        .pb_addr         (pb_addr),
        .pb_wdata        (pb_wdata),
        .pb_ack          (pb_ack),
        .rd_data         (rd_data),
        .req_err         (req_err),
        .busy            (busy),
        .ram_rdy         (ram_rdy),
        .max_ram_address (max_ram_address),
        .ram_address     (ram_address),
        .ram_data_in     (ram_data_in),
        .ram_write_enable(ram_write_enable),
        .ram_read_request(ram_read_request),
        .ram_read_ack    (ram_read_ack),
        .ram_data_out    (ram_data_out),
        .ram_rd_data_pres(ram_rd_data_pres)
    );

    // ------------------------------------------------------------------
    // RAM wrapper model
    // ------------------------------------------------------------------
    logic [7:0] mem [0:1023];
    int pres_delay = 1;
    int pres_cnt   = -1;

    always @(negedge clk) begin
        ram_rd_data_pres = 1'b0;
        if (ram_write_enable) mem[ram_address[9:0]] = ram_data_in;
        if (ram_read_request) begin
            pres_cnt = pres_delay;
        end else if (pres_cnt > 0) begin
            pres_cnt = pres_cnt - 1;
            if (pres_cnt == 0) begin
                ram_rd_data_pres = 1'b1;
                ram_data_out     = mem[ram_address[9:0]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_rec_ack"},  32'(rec_ack),          32'd0);
        chk({pfx, "_play_ack"}, 32'(play_ack),         32'd0);
        chk({pfx, "_pb_ack"},   32'(pb_ack),           32'd0);
        chk({pfx, "_rd_data"},  32'(rd_data),          32'd0);
        chk({pfx, "_req_err"},  32'(req_err),          32'd0);
        chk({pfx, "_busy"},     32'(busy),             32'd0);
        chk({pfx, "_addr"},     32'(ram_address),      32'd0);
        chk({pfx, "_din"},      32'(ram_data_in),      32'd0);
        chk({pfx, "_we"},       32'(ram_write_enable), 32'd0);
        chk({pfx, "_rreq"},     32'(ram_read_request), 32'd0);
        chk({pfx, "_rack"},     32'(ram_read_ack),     32'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int waited;
        int play_gap, pb_gap, last_rd, n_play, n_pb, n_rec, rec_t, k, nacks;
        int order [0:2];
        int n_ord;

        pb_reset        = 1'b1;
        ram_rdy         = 1'b1;
        max_ram_address = MAX_ADDR;
        rec_req = 1'b0; rec_addr = '0; rec_data = '0;
        play_req = 1'b0; play_addr = '0;
        pb_req = 1'b0; pb_we = 1'b0; pb_addr = '0; pb_wdata = '0;

        // --- reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        pb_reset = 1'b0;
        @(negedge clk);

        // --- record write 0xA5 -> 0x10
        rec_addr = 26'h10; rec_data = 8'hA5; rec_req = 1'b1;
        @(negedge clk);
        chk("t1_rec_ack",  32'(rec_ack),          32'd1);
        chk("t1_we",       32'(ram_write_enable), 32'd1);
        chk("t1_addr",     32'(ram_address),      32'h10);
        chk("t1_din",      32'(ram_data_in),      32'hA5);
        chk("t1_busy",     32'(busy),             32'd1);
        chk("t1_play_ack", 32'(play_ack),         32'd0);
        rec_req = 1'b0;
        @(negedge clk);
        chk("t1_ack_pulse", 32'(rec_ack),          32'd0);
        chk("t1_we_pulse",  32'(ram_write_enable), 32'd0);
        chk("t1_idle",      32'(busy),             32'd0);
        chk("t1_addr_held", 32'(ram_address),      32'h10);

        // --- playback read, data 5 cycles after the read request
        pres_delay = 5; play_addr = 26'h10; play_req = 1'b1;
        @(negedge clk);
        chk("t2_read_req", 32'(ram_read_request), 32'd1);
        chk("t2_no_ack",   32'(play_ack),         32'd0);
        waited = 0;
        while (!play_ack && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("t2_ack_latency", 32'(waited),       32'd6);
        chk("t2_read_ack",    32'(ram_read_ack), 32'd1);
        chk("t2_rd_data",     32'(rd_data),      32'hA5);
        chk("t2_no_err",      32'(req_err),      32'd0);
        play_req = 1'b0;
        @(negedge clk);
        chk("t2_ack_pulse",  32'(play_ack),     32'd0);
        chk("t2_rack_pulse", 32'(ram_read_ack), 32'd0);
        chk("t2_idle",       32'(busy),         32'd0);
        repeat (3) @(negedge clk);
        chk("t2_rd_held",    32'(rd_data),      32'hA5);

        // --- play + pb reads held, record every 4 cycles
        pres_delay = 1; play_addr = 26'h10; pb_addr = 26'h10; pb_we = 1'b0;
        play_gap = 0; pb_gap = 0; last_rd = 0;
        n_play = 0; n_pb = 0; n_rec = 0; rec_t = 0; k = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            nacks = int'(rec_ack) + int'(play_ack) + int'(pb_ack);
            chk("t3_single_ack", 32'(nacks <= 1), 32'd1);
            if (rec_ack) begin
                chk("t3_rec_latency", 32'((c - rec_t) <= 5), 32'd1);
                rec_req = 1'b0;
                n_rec++;
            end
            if (play_ack) begin
                chk("t3_play_alternates", 32'(last_rd != 1), 32'd1);
                chk("t3_play_data", 32'(rd_data), 32'hA5);
                last_rd = 1; play_req = 1'b0; play_gap = 2; n_play++;
            end
            if (pb_ack) begin
                chk("t3_pb_alternates", 32'(last_rd != 2), 32'd1);
                chk("t3_pb_data", 32'(rd_data), 32'hA5);
                last_rd = 2; pb_req = 1'b0; pb_gap = 2; n_pb++;
            end
            if (!rec_req && !rec_ack && (c % 4 == 0)) begin
                rec_addr = 26'(32'h40 + k);
                rec_data = 8'(k);
                rec_req  = 1'b1;
                rec_t    = c;
                k++;
            end
            if (play_gap > 0) play_gap--;
            else if (!play_req) play_req = 1'b1;
            if (pb_gap > 0) pb_gap--;
            else if (!pb_req) pb_req = 1'b1;
        end
        rec_req = 1'b0; play_req = 1'b0; pb_req = 1'b0;
        repeat (8) @(negedge clk);
        chk("t3_drained",   32'(busy), 32'd0);
        chk("t3_play_served", 32'(n_play >= 3), 32'd1);
        chk("t3_pb_served",   32'(n_pb >= 3),   32'd1);
        chk("t3_fair",        32'((n_play - n_pb <= 1) && (n_pb - n_play <= 1)), 32'd1);
        chk("t3_rec_served",  32'(n_rec >= 4),  32'd1);

        // --- pb write beyond the RAM is rejected
        pb_we = 1'b1; pb_addr = MAX_ADDR + 26'd1; pb_wdata = 8'h99; pb_req = 1'b1;
        @(negedge clk);
        chk("t4_rej_ack",  32'(pb_ack),           32'd1);
        chk("t4_rej_err",  32'(req_err),          32'd1);
        chk("t4_rej_no_we",32'(ram_write_enable), 32'd0);
        chk("t4_rej_busy", 32'(busy),             32'd1);
        pb_req = 1'b0;
        @(negedge clk);
        chk("t4_rej_ack_pulse", 32'(pb_ack),           32'd0);
        chk("t4_rej_err_pulse", 32'(req_err),          32'd0);
        chk("t4_rej_idle",      32'(busy),             32'd0);
        chk("t4_rej_no_we2",    32'(ram_write_enable), 32'd0);
        // the highest valid address is accepted
        pb_addr = MAX_ADDR; pb_req = 1'b1;
        @(negedge clk);
        chk("t4_max_ack", 32'(pb_ack),           32'd1);
        chk("t4_max_we",  32'(ram_write_enable), 32'd1);
        chk("t4_max_err", 32'(req_err),          32'd0);
        chk("t4_max_din", 32'(ram_data_in),      32'h99);
        pb_req = 1'b0;
        @(negedge clk);

        // --- reset during READ_WAIT, then a fresh record write
        pres_delay = -1; play_addr = 26'h10; play_req = 1'b1;
        @(negedge clk);
        chk("t5_read_req", 32'(ram_read_request), 32'd1);
        repeat (2) @(negedge clk);
        chk("t5_waiting",  32'(busy),    32'd1);
        chk("t5_rd_before",32'(rd_data), 32'hA5);
        pb_reset = 1'b1;
        #1;
        chk_all_zero("t5_rst");
        play_req = 1'b0;
        @(negedge clk);
        pb_reset = 1'b0;
        @(negedge clk);
        chk("t5_no_resume", 32'(busy), 32'd0);
        rec_addr = 26'h22; rec_data = 8'h5A; rec_req = 1'b1;
        @(negedge clk);
        chk("t5_rec_ack",  32'(rec_ack),          32'd1);
        chk("t5_rec_we",   32'(ram_write_enable), 32'd1);
        chk("t5_rec_addr", 32'(ram_address),      32'h22);
        chk("t5_rec_din",  32'(ram_data_in),      32'h5A);
        rec_req = 1'b0;
        @(negedge clk);

        // --- rec, play and pb raised together: rec, then play, then pb
        pres_delay = 2;
        rec_addr = 26'h30; rec_data = 8'h11; rec_req = 1'b1;
        play_addr = 26'h10; play_req = 1'b1;
        pb_addr = 26'h10; pb_we = 1'b0; pb_req = 1'b1;
        n_ord = 0;
        order[0] = 0; order[1] = 0; order[2] = 0;
        for (int c = 0; c < 40 && n_ord < 3; c++) begin
            @(negedge clk);
            if (rec_ack)  begin order[n_ord] = 1; n_ord++; rec_req  = 1'b0; end
            if (play_ack) begin if (n_ord < 3) order[n_ord] = 2; n_ord++; play_req = 1'b0; end
            if (pb_ack)   begin if (n_ord < 3) order[n_ord] = 3; n_ord++; pb_req   = 1'b0; end
        end
        chk("t6_count",  32'(n_ord),    32'd3);
        chk("t6_first",  32'(order[0]), 32'd1);
        chk("t6_second", 32'(order[1]), 32'd2);
        chk("t6_third",  32'(order[2]), 32'd3);
        rec_req = 1'b0; play_req = 1'b0; pb_req = 1'b0;
        repeat (2) @(negedge clk);

        // --- ram_rdy low holds everything off
        ram_rdy = 1'b0;
        rec_addr = 26'h31; rec_data = 8'h77; rec_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t7_no_we",   32'(ram_write_enable), 32'd0);
            chk("t7_no_ack",  32'(rec_ack),          32'd0);
            chk("t7_no_busy", 32'(busy),             32'd0);
        end
        ram_rdy = 1'b1;
        @(negedge clk);
        chk("t7_rec_ack", 32'(rec_ack),          32'd1);
        chk("t7_we",      32'(ram_write_enable), 32'd1);
        chk("t7_addr",    32'(ram_address),      32'h31);
        rec_req = 1'b0;
        @(negedge clk);

        // --- pb read whose data never arrives times out
        pres_delay = -1; pb_we = 1'b0; pb_addr = 26'h10; pb_req = 1'b1;
        @(negedge clk);
        chk("t8_read_req", 32'(ram_read_request), 32'd1);
        waited = 0;
        while (!pb_ack && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("t8_ack_latency", 32'(waited),       32'd9);
        chk("t8_err",         32'(req_err),      32'd1);
        chk("t8_rd_zero",     32'(rd_data),      32'd0);
        chk("t8_read_ack",    32'(ram_read_ack), 32'd1);
        pb_req = 1'b0;
        @(negedge clk);
        chk("t8_idle",       32'(busy),         32'd0);
        chk("t8_err_pulse",  32'(req_err),      32'd0);
        chk("t8_rack_pulse", 32'(ram_read_ack), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
